bound_flasher_fsm: RTL and testbench

//  16-lamp "bound flasher": one FLICK pulse starts a fixed on/off sweep over LED[15:0].

---
 rtl/bound_flasher_pkg.sv | 23 ++
 rtl/bound_flasher_if.sv | 11 +
 rtl/bound_flasher_fsm_led_thermometer.sv | 16 +
 rtl/bound_flasher_fsm.sv | 111 +++++++++++
 tb/tb_bound_flasher_fsm.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/bound_flasher_pkg.sv
// Shared types and bound constants for the 16-lamp bound flasher.
package bound_flasher_pkg;

   localparam int NUM_LEDS = 16;
   localparam int CNT_W    = 5;

   // Bounds are lamp indices; an upward sweep ends with the bound lamp lit.
   localparam logic [CNT_W-1:0] B_0  = 5'd0;
   localparam logic [CNT_W-1:0] B_5  = 5'd5;
   localparam logic [CNT_W-1:0] B_10 = 5'd10;
   localparam logic [CNT_W-1:0] B_15 = 5'd15;

   typedef enum logic [2:0] {
      IDLE,
      UP_0_15,
      DOWN_15_5,
      UP_5_10,
      DOWN_10_0,
      UP_0_5,
      DOWN_5_0
   } state_t;

endpackage

// File: rtl/bound_flasher_if.sv
// Flick request and lamp drive bundle between the board side and the flasher.
interface bound_flasher_if;
   import bound_flasher_pkg::*;

   logic                FLICK;
   logic [NUM_LEDS-1:0] LED;

   modport master (output FLICK, input LED);
   modport slave  (input FLICK, output LED);

endinterface

// File: rtl/bound_flasher_fsm_led_thermometer.sv
// Lamp count to thermometer code: the lowest i_cnt lamps are lit.
module led_thermometer
   import bound_flasher_pkg::*;
(
   input  logic [CNT_W-1:0]    i_cnt,
   output logic [NUM_LEDS-1:0] o_led
);

   always_comb begin
      o_led = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         o_led[i] = (i_cnt > CNT_W'(i));
      end
   end

endmodule

// File: rtl/bound_flasher_fsm.sv
// Bound flasher sequencer: state + lamp count registers, registered LED output.
// Build option BOUND_FLASHER_FLICK_SYNC_EN adds a 2-flop synchronizer on FLICK.
//
// state     | meaning
// IDLE      | all lamps off, waiting for FLICK
// UP_0_15   | lighting one lamp per clock until all 16 are on
// DOWN_15_5 | extinguishing until 5 lit; FLICK there climbs to 16 again
// UP_5_10   | lighting until 11 lit
// DOWN_10_0 | extinguishing until 0 lit; FLICK there climbs to 11 again
// UP_0_5    | lighting until 6 lit
// DOWN_5_0  | extinguishing until 0 lit, then back to IDLE
module bound_flasher_fsm
   import bound_flasher_pkg::*;
(
   input  logic            CLK,
   input  logic            RST,
   bound_flasher_if.slave  bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [NUM_LEDS-1:0] r_led;
   logic [NUM_LEDS-1:0] w_led_nxt;
   logic                w_flick;

`ifdef BOUND_FLASHER_FLICK_SYNC_EN
   logic [1:0] r_flick_sync;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_flick_sync <= '0;
      else     r_flick_sync <= {r_flick_sync[0], bus.FLICK};
   end

   assign w_flick = r_flick_sync[1];
`else
   assign w_flick = bus.FLICK;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_led   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_led   <= w_led_nxt;
      end
   end

   // Down states park on their lower bound for one edge so FLICK can pick the next climb.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            w_cnt_nxt = B_0;
            if (w_flick) begin
               w_state_nxt = UP_0_15;
               w_cnt_nxt   = B_0 + 5'd1;
            end
         end
         UP_0_15: begin
            w_cnt_nxt = r_cnt + 5'd1;
            if (r_cnt == B_15) w_state_nxt = DOWN_15_5;
         end
         DOWN_15_5: begin
            if (r_cnt == B_5) begin
               w_cnt_nxt   = r_cnt + 5'd1;
               w_state_nxt = w_flick ? UP_0_15 : UP_5_10;
            end else begin
               w_cnt_nxt = r_cnt - 5'd1;
            end
         end
         UP_5_10: begin
            w_cnt_nxt = r_cnt + 5'd1;
            if (r_cnt == B_10) w_state_nxt = DOWN_10_0;
         end
         DOWN_10_0: begin
            if (r_cnt == B_0) begin
               w_cnt_nxt   = r_cnt + 5'd1;
               w_state_nxt = w_flick ? UP_5_10 : UP_0_5;
            end else begin
               w_cnt_nxt = r_cnt - 5'd1;
            end
         end
         UP_0_5: begin
            w_cnt_nxt = r_cnt + 5'd1;
            if (r_cnt == B_5) w_state_nxt = DOWN_5_0;
         end
         DOWN_5_0: begin
            w_cnt_nxt = r_cnt - 5'd1;
            if (r_cnt == B_0 + 5'd1) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = B_0;
         end
      endcase
   end

   led_thermometer u_led_thermometer (
      .i_cnt (w_cnt_nxt),
      .o_led (w_led_nxt)
   );

   assign bus.LED = r_led;

endmodule

// File: tb/tb_bound_flasher_fsm.sv
// Directed bench for bound_flasher_fsm (default build, FLICK used unsynchronized).
`timescale 1ns/1ps
module tb_bound_flasher_fsm;

   logic CLK;
   logic RST;
   int   vectors;
   int   miscompares;

   bound_flasher_if bus ();

   bound_flasher_fsm dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [15:0] therm(input int n);
      logic [15:0] e;
      e = '0;
      for (int i = 0; i < 16; i++) e[i] = (i < n);
      return e;
   endfunction

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One sweep segment: expected lamp count walks from->to, one edge per step.
   // FLICK is high on the first 'head' edges, the last 'tail' edges, and odd steps when burst.
   task automatic seg(input int from, input int to, input int head, input int tail,
                      input bit burst);
      int len;
      int n;
      int dir;
      len = (from > to) ? (from - to + 1) : (to - from + 1);
      dir = (from > to) ? -1 : 1;
      n   = from;
      for (int i = 0; i < len; i++) begin
         bus.FLICK = (i < head) || (i >= len - tail) || (burst && i[0]);
         @(posedge CLK);
         #1;
         check($sformatf("seg_%0d_to_%0d_n%0d", from, to, n), bus.LED, therm(n));
         n = n + dir;
      end
      bus.FLICK = 1'b0;
   endtask

   task automatic idle(input int k, input string tag);
      bus.FLICK = 1'b0;
      for (int i = 0; i < k; i++) begin
         @(posedge CLK);
         #1;
         check(tag, bus.LED, 16'h0000);
      end
   endtask

   task automatic normal_run(input bit burst);
      seg(1, 16, 1, 0, burst);
      seg(15, 5, 0, 0, burst);
      seg(6, 11, 0, 0, 1'b0);
      seg(10, 0, 0, 0, burst);
      seg(1, 6, 0, 0, 1'b0);
      seg(5, 0, 0, 0, burst);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      RST         = 1'b1;
      bus.FLICK   = 1'b0;

      // Reset state, FLICK coincident with RST ignored
      #2;
      check("reset_led", bus.LED, 16'h0000);
      bus.FLICK = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check("flick_during_reset", bus.LED, 16'h0000);
      RST = 1'b0;
      idle(3, "idle_after_reset");

      // Scenario 1: full normal run, then stays idle
      normal_run(1'b0);
      idle(3, "idle_after_run1");

      // Scenario 2: async reset at n=8 in UP_0_15
      seg(1, 8, 1, 0, 1'b0);
      #3;
      RST = 1'b1;
      #1;
      check("async_reset_up", bus.LED, 16'h0000);
      bus.FLICK = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      check("flick_with_rst_midrun", bus.LED, 16'h0000);
      bus.FLICK = 1'b0;
      RST = 1'b0;
      idle(3, "idle_after_reset2");

      // Scenario 3: reset in DOWN_15_5 (n=12), then a full run
      seg(1, 16, 1, 0, 1'b0);
      seg(15, 12, 0, 0, 1'b0);
      #3;
      RST = 1'b1;
      #1;
      check("async_reset_down", bus.LED, 16'h0000);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      idle(2, "idle_after_reset3");
      normal_run(1'b0);
      idle(2, "idle_after_run3");

      // Scenario 4: kickback at both lower bounds
      seg(1, 16, 1, 0, 1'b0);
      seg(15, 5, 0, 0, 1'b0);
      seg(6, 16, 1, 0, 1'b0);
      seg(15, 5, 0, 0, 1'b0);
      seg(6, 11, 0, 0, 1'b0);
      seg(10, 0, 0, 0, 1'b0);
      seg(1, 11, 1, 0, 1'b0);
      seg(10, 0, 0, 0, 1'b0);
      seg(1, 6, 0, 0, 1'b0);
      seg(5, 0, 0, 0, 1'b0);
      idle(2, "idle_after_kick");

      // Scenario 5: FLICK bursts away from bound decision points
      normal_run(1'b1);
      idle(2, "idle_after_burst");

      // Scenario 6: FLICK held 4 cycles across each lower bound, then held into IDLE
      seg(1, 16, 1, 0, 1'b0);
      seg(15, 5, 0, 2, 1'b0);
      seg(6, 16, 2, 0, 1'b0);
      seg(15, 5, 0, 0, 1'b0);
      seg(6, 11, 0, 0, 1'b0);
      seg(10, 0, 0, 2, 1'b0);
      seg(1, 11, 2, 0, 1'b0);
      seg(10, 0, 0, 0, 1'b0);
      seg(1, 6, 0, 0, 1'b0);
      seg(5, 0, 0, 2, 1'b0);
      seg(1, 4, 1, 0, 1'b0);
      #3;
      RST = 1'b1;
      #1;
      check("final_reset", bus.LED, 16'h0000);
      @(posedge CLK);
      #1;
      RST = 1'b0;
      idle(2, "idle_final");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
